// File: rtl/sc_stream_counter_pkg.sv
// Shared definitions for the stochastic stream counter: FSM state encodings.
package sc_stream_counter_pkg;
  localparam logic [1:0] SC_ST_IDLE  = 2'd0;
  localparam logic [1:0] SC_ST_ACCUM = 2'd1;
  localparam logic [1:0] SC_ST_HOLD  = 2'd2;
endpackage

// File: rtl/sc_stream_counter_if.sv
// Stream-in / result-out bundle between the SC mux side and the PE result path.
interface sc_stream_counter_if #(
  parameter int LANES = 2,
  parameter int OUT_W = 10
);
  logic                   start;
  logic                   in_valid;
  logic [LANES-1:0]       in_bits;
  logic                   busy;
  logic                   out_valid;
  logic                   out_ready;
  logic [LANES*OUT_W-1:0] out_count;

  modport master (
    output start, in_valid, in_bits, out_ready,
    input  busy, out_valid, out_count
  );
  modport slave (
    input  start, in_valid, in_bits, out_ready,
    output busy, out_valid, out_count
  );
endinterface

// File: rtl/sc_stream_counter_ones_counter.sv
// Per-lane ones counter; clears on start, increments on each accepted one bit.
module sc_ones_counter #(
  parameter int CNT_W = 9
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             i_clr,
  input  logic             i_en,
  input  logic             i_bit,
  output logic [CNT_W-1:0] o_count
);
  logic [CNT_W-1:0] r_count;

  always_ff @(posedge clk) begin
    if (rst || i_clr)      r_count <= '0;
    else if (i_en && i_bit) r_count <= r_count + 1'b1;
  end

  assign o_count = r_count;
endmodule

// File: rtl/sc_stream_counter.sv
// Stochastic-to-binary converter: counts ones per lane over 2**LEN_LOG2 valid bits.
// Define SC_BIPOLAR_EN for signed 2*count-N output; default is unipolar count.
module sc_stream_counter
  import sc_stream_counter_pkg::*;
#(
  parameter  int LANES    = 2,
  parameter  int LEN_LOG2 = 8,
  localparam int OUT_W    = LEN_LOG2 + 2
) (
  input logic                clk,
  input logic                rst,
  sc_stream_counter_if.slave bus
);
  localparam int CNT_W = LEN_LOG2 + 1;

  logic [1:0]                       r_state;
  logic [LEN_LOG2-1:0]              r_bit_cnt;
  logic [LANES-1:0][OUT_W-1:0]      r_out_count;
  logic [LANES-1:0][CNT_W-1:0]      w_lane_cnt;
  logic [LANES-1:0][OUT_W-1:0]      w_result;
  logic                             w_start, w_acc, w_last;

  assign w_start = (r_state == SC_ST_IDLE) && bus.start;
  assign w_acc   = (r_state == SC_ST_ACCUM) && bus.in_valid;
  assign w_last  = w_acc && (r_bit_cnt == {LEN_LOG2{1'b1}});

  for (genvar g = 0; g < LANES; g++) begin : g_lane
    logic [CNT_W-1:0] w_final;

    sc_ones_counter #(.CNT_W(CNT_W)) u_cnt (
      .clk     (clk),
      .rst     (rst),
      .i_clr   (w_start),
      .i_en    (w_acc),
      .i_bit   (bus.in_bits[g]),
      .o_count (w_lane_cnt[g])
    );

    // The result register loads on the same edge as the last bit, so fold it in here.
    assign w_final = w_lane_cnt[g] + CNT_W'(bus.in_bits[g]);
`ifdef SC_BIPOLAR_EN
    assign w_result[g] = {w_final, 1'b0} - (OUT_W'(1) << LEN_LOG2);
`else
    assign w_result[g] = {1'b0, w_final};
`endif
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= SC_ST_IDLE;
      r_bit_cnt   <= '0;
      r_out_count <= '0;
    end else begin
      case (r_state)
        SC_ST_IDLE: begin
          if (bus.start) begin
            r_state   <= SC_ST_ACCUM;
            r_bit_cnt <= '0;
          end
        end
        SC_ST_ACCUM: begin
          if (bus.in_valid) r_bit_cnt <= r_bit_cnt + 1'b1;
          if (w_last) begin
            r_state     <= SC_ST_HOLD;
            r_out_count <= w_result;
          end
        end
        SC_ST_HOLD: begin
          if (bus.out_ready) r_state <= SC_ST_IDLE;
        end
        default: r_state <= SC_ST_IDLE;
      endcase
    end
  end

  assign bus.busy      = (r_state != SC_ST_IDLE);
  assign bus.out_valid = (r_state == SC_ST_HOLD);
  assign bus.out_count = r_out_count;
endmodule

// File: tb/tb_sc_stream_counter.sv
// Scoreboard bench for sc_stream_counter (LANES=2, LEN_LOG2=8).
module tb_sc_stream_counter;
  localparam int LANES = 2, LEN_LOG2 = 8, OUT_W = 10, N = 256;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  sc_stream_counter_if #(.LANES(LANES), .OUT_W(OUT_W)) bus();
  sc_stream_counter #(.LANES(LANES), .LEN_LOG2(LEN_LOG2)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_cmp = 0;
  int n_bad = 0;
  logic [LANES*OUT_W-1:0] exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [OUT_W-1:0] map(input int c);
`ifdef SC_BIPOLAR_EN
    return OUT_W'(2 * c - N);
`else
    return OUT_W'(c);
`endif
  endfunction

  function automatic logic [1:0] pat(input int mode, input int i);
    case (mode)
      0:       return 2'b11;
      1:       return 2'b00;
      default: return {1'b1, (i % 2 == 0)};
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Monitor: every accepted result is compared against the oldest expectation.
  always @(negedge clk) begin
    if (bus.out_valid && bus.out_ready) begin
      if (exp_q.size() == 0) begin
        n_cmp++;
        n_bad++;
        $display("FAIL unexpected_result: got %0h expected none", bus.out_count);
      end else begin
        check("result", 32'(bus.out_count), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic convert(input int mode, input bit stall, input int e0, input int e1,
                         input int hold, input bit poke, input string tag);
    int i;
    int cyc;
    logic [LANES*OUT_W-1:0] e;
    e = {map(e1), map(e0)};
    exp_q.push_back(e);
    i = 0;
    cyc = 0;
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    check({tag, "_busy"}, 32'(bus.busy), 32'd1);
    while (i < N) begin
      if (stall && cyc[0]) begin
        bus.in_valid = 1'b0;
        bus.in_bits  = 2'($urandom);
      end else begin
        bus.in_valid = 1'b1;
        bus.in_bits  = pat(mode, i);
        i++;
      end
      bus.start = poke && (i == 50);
      if (i == N) check({tag, "_early_valid"}, 32'(bus.out_valid), 32'd0);
      tick();
      cyc++;
    end
    bus.start    = 1'b0;
    bus.in_valid = 1'b0;
    check({tag, "_latency"}, 32'(bus.out_valid), 32'd1);
    for (int k = 0; k < hold; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bits  = 2'(k);
      bus.start    = poke && (k == hold / 2);
      tick();
      check({tag, "_hold_valid"}, 32'(bus.out_valid), 32'd1);
      check({tag, "_hold_stable"}, 32'(bus.out_count), 32'(e));
    end
    bus.in_valid  = 1'b0;
    bus.start     = poke;
    bus.out_ready = 1'b1;
    tick();
    bus.out_ready = 1'b0;
    bus.start     = 1'b0;
    check({tag, "_release_valid"}, 32'(bus.out_valid), 32'd0);
    check({tag, "_release_busy"}, 32'(bus.busy), 32'd0);
    tick();
    tick();
    check({tag, "_idle_busy"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    bus.start     = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_bits   = '0;
    bus.out_ready = 1'b0;
    repeat (3) tick();
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_valid", 32'(bus.out_valid), 32'd0);
    check("reset_count", 32'(bus.out_count), 32'd0);
    rst = 1'b0;
    tick();

    convert(0, 1'b0, 256, 256, 0, 1'b0, "ones");

    // Abort mid-conversion after 100 bits; no result may appear.
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    for (int k = 0; k < 100; k++) begin
      bus.in_valid = 1'b1;
      bus.in_bits  = 2'b11;
      tick();
    end
    bus.in_valid = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_valid", 32'(bus.out_valid), 32'd0);
    check("abort_count", 32'(bus.out_count), 32'd0);
    tick();

    convert(2, 1'b0, 128, 256, 0, 1'b0, "alt");
    convert(1, 1'b0, 0, 0, 0, 1'b0, "zeros");
    convert(2, 1'b1, 128, 256, 0, 1'b0, "stall");
    convert(0, 1'b0, 256, 256, 20, 1'b1, "hold_poke");

    tick();
    check("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
